// File: rtl/txt_write_arbiter.sv
// txt_write_arbiter: round-robin sharing of the txtScreen character write port, each write
// driven through a fixed SETUP/STROBE/HOLD nWr sequence. Define TXT_ARB_CLEAR_EN for the clear sequencer.
module txt_write_arbiter #(
  parameter int NREQ         = 4,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STROBE_LOW   = 1,
  parameter int SCREEN_CHARS = 2400
) (
  input  logic                   iVGA_CLK,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic [ADDR_W-1:0]      char_addr,
  output logic [DATA_W-1:0]      char_data,
  output logic                   char_nWr
);
  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_q, rr_d, grant_q, grant_d;
  logic [CNT_W-1:0]  strb_q, strb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              nwr_q, nwr_d, busy_q, busy_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Walk downward so the lowest offset from the rr pointer is the one that sticks.
  logic              any_req;
  logic [PTR_W-1:0]  pick;
  logic [PTR_W:0]    sum;
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
      if (req[sum[PTR_W-1:0]]) begin
        any_req = 1'b1;
        pick    = sum[PTR_W-1:0];
      end
    end
  end

`ifdef TXT_ARB_CLEAR_EN
  localparam int CLR_W = (SCREEN_CHARS > 1) ? $clog2(SCREEN_CHARS) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(SCREEN_CHARS - 1);
  logic             clr_busy_q, clr_busy_d, clr_pend_q, clr_pend_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    strb_d  = strb_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = '0;
`ifdef TXT_ARB_CLEAR_EN
    clr_busy_d = clr_busy_q;
    clr_pend_d = clr_pend_q;
    clr_cnt_d  = clr_cnt_q;
    if (clr_start && state_q != S_IDLE && !clr_busy_q) clr_pend_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef TXT_ARB_CLEAR_EN
        if (clr_start || clr_pend_q) begin
          clr_busy_d = 1'b1;
          clr_pend_d = 1'b0;
          clr_cnt_d  = '0;
          addr_d     = '0;
          data_d     = DATA_W'(8'h20);
          state_d    = S_SETUP;
        end else
`endif
        if (any_req) begin
          grant_d = pick;
          addr_d  = addr_arr[pick];
          data_d  = data_arr[pick];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        strb_d  = CNT_W'(STROBE_LOW - 1);
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (strb_q == '0) state_d = S_HOLD;
        else              strb_d  = strb_q - 1'b1;
      end
      S_HOLD: begin
`ifdef TXT_ARB_CLEAR_EN
        // Clear writes chain straight back into SETUP; no ACK and rr pointer untouched.
        if (clr_busy_q) begin
          if (clr_cnt_q == CLR_LAST) begin
            clr_busy_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            addr_d    = ADDR_W'(clr_cnt_q + 1'b1);
            state_d   = S_SETUP;
          end
        end else
`endif
        begin
          ack_d[grant_q] = 1'b1;
          state_d        = S_ACK;
        end
      end
      S_ACK: begin
        rr_d    = (grant_q == PTR_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    nwr_d  = (state_d != S_STROBE);
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      strb_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      nwr_q   <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= '0;
`ifdef TXT_ARB_CLEAR_EN
      clr_busy_q <= 1'b0;
      clr_pend_q <= 1'b0;
      clr_cnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      nwr_q   <= nwr_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
`ifdef TXT_ARB_CLEAR_EN
      clr_busy_q <= clr_busy_d;
      clr_pend_q <= clr_pend_d;
      clr_cnt_q  <= clr_cnt_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign char_addr = addr_q;
  assign char_data = data_q;
  assign char_nWr  = nwr_q;

`ifdef TXT_ARB_CLEAR_EN
  assign clr_busy = clr_busy_q;
`else
  localparam int UNUSED_SCREEN_CHARS = SCREEN_CHARS;
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign clr_busy         = 1'b0;
`endif

endmodule
